// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants and the shared colour type for the VGA scan generator.
// Also holds the colour-bar lookup used when VGA_TESTBARS_EN is defined.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black falls out of
  // the index bits: red off for idx[1], green off for idx[2], blue off for idx[0].
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    c.r = {8{~idx[1]}};
    c.g = {8{~idx[2]}};
    c.b = {8{~idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One scan axis: a wrapping position counter with its visible-region and sync-window decodes.
// Used once for the horizontal axis (en = pixel tick) and once for vertical (en = line wrap).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             active,
  output logic             sync_n
);

  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = SYNC_START + SYNC;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wrap    = en && (count_q == CNT_W'(TOTAL - 1));
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign active = (count_q < CNT_W'(ACTIVE));
  assign sync_n = !((count_q >= CNT_W'(SYNC_START)) && (count_q < CNT_W'(SYNC_END)));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan/timing generator: emits x/y to the pixel colour logic and a one-pixel-delayed,
// blanked colour plus syncs to the DAC. Optional colour bars under macro VGA_TESTBARS_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             test_mode,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             vga_clk,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n,
  output logic             vga_sync_n,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic             frame_start
);

  logic div_q, div_d, pix_en;

  // The pixel tick is the cycle the divider sits at 1, so the DAC clock (the
  // divider bit itself) falls as outputs change and rises mid-pixel.
  generate
    if (CLK_DIV == 1) begin : g_div1
      assign pix_en  = 1'b1;
      assign div_d   = 1'b0;
      assign vga_clk = ~clk;
    end else begin : g_div2
      assign pix_en  = div_q;
      assign div_d   = ~div_q;
      assign vga_clk = div_q;
    end
  endgenerate

  logic [CNT_W-1:0] h_count, v_count;
  logic             h_wrap, h_active, h_sync_n;
  logic             v_wrap, v_active, v_sync_n;

  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(clk), .rst_n(rst_n), .en(pix_en),
    .count(h_count), .wrap(h_wrap), .active(h_active), .sync_n(h_sync_n)
  );

  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(clk), .rst_n(rst_n), .en(h_wrap),
    .count(v_count), .wrap(v_wrap), .active(v_active), .sync_n(v_sync_n)
  );

  rgb_t pix_rgb;

`ifdef VGA_TESTBARS_EN
  logic [2:0] bar_idx;
  assign bar_idx = 3'(h_count / CNT_W'(80));
  always_comb begin
    pix_rgb = '{r: r_in, g: g_in, b: b_in};
    if (test_mode) begin
      pix_rgb = bar_colour(bar_idx);
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pix_rgb = '{r: r_in, g: g_in, b: b_in};
`endif

  logic hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic fs_q, fs_d, at_origin_q, at_origin_d;
  rgb_t rgb_q, rgb_d;

  // at_origin marks that the counters sit at (0,0) and the next tick outputs it.
  always_comb begin
    hs_d        = hs_q;
    vs_d        = vs_q;
    blank_n_d   = blank_n_q;
    rgb_d       = rgb_q;
    fs_d        = pix_en && at_origin_q;
    at_origin_d = at_origin_q;
    if (v_wrap) begin
      at_origin_d = 1'b1;
    end else if (pix_en) begin
      at_origin_d = 1'b0;
    end
    if (pix_en) begin
      hs_d      = h_sync_n;
      vs_d      = v_sync_n;
      blank_n_d = h_active && v_active;
      rgb_d     = (h_active && v_active) ? pix_rgb : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_n_q   <= 1'b0;
      rgb_q       <= '0;
      fs_q        <= 1'b0;
      at_origin_q <= 1'b1;
    end else begin
      div_q       <= div_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_n_q   <= blank_n_d;
      rgb_q       <= rgb_d;
      fs_q        <= fs_d;
      at_origin_q <= at_origin_d;
    end
  end

  assign x           = h_count;
  assign y           = v_count;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: pixel-count reference model feeding a per-clock scoreboard,
// plus run-length checks on syncs and frame_start. Vertical timing is shortened so frames fit.
module tb_vga_timing_gen;

  localparam int HA = 640, HFP = 16, HSY = 96, HBP = 48;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VA = 4, VFP = 1, VSY = 2, VBP = 2;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`ifdef VGA_TESTBARS_EN
  localparam bit BARS_EN = 1'b1;
`else
  localparam bit BARS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, test_mode;
  logic [7:0] r_in, g_in, b_in;
  logic [9:0] x, y;
  logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .test_mode(test_mode),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .x(x), .y(y), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vclk;
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic [23:0] rgb;
    logic        fs;
  } exp_t;

  exp_t     sb_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  bit       meas_en  = 1'b0;
  bit [7:0] lut_r[256], lut_g[256], lut_b[256];

  // External pixel generator: a marker at the origin, FF outside the visible area.
  function automatic logic [23:0] pixel_colour(input int h, input int v);
    int k;
    if (h == 0 && v == 0) return 24'hAA5511;
    if (h >= HA || v >= VA) return 24'hFFFFFF;
    k = (h * 7 + v * 13) & 255;
    return {lut_r[k], lut_g[k], lut_b[k]};
  endfunction

  // State expected just after the e-th clock edge since reset release.
  function automatic exp_t model(input int e, input bit tm);
    exp_t m;
    int   p, q, h, v;
    p = e / 2;
    m.x    = 10'(p % HT);
    m.y    = 10'((p / HT) % VT);
    m.vclk = (e % 2) == 1;
    if (p == 0) begin
      m.hs = 1'b1; m.vs = 1'b1; m.blank_n = 1'b0; m.rgb = '0; m.fs = 1'b0;
    end else begin
      q = p - 1;
      h = q % HT;
      v = (q / HT) % VT;
      m.hs      = !(h >= HA + HFP && h < HA + HFP + HSY);
      m.vs      = !(v >= VA + VFP && v < VA + VFP + VSY);
      m.blank_n = (h < HA) && (v < VA);
      if (!m.blank_n) m.rgb = '0;
      else if (BARS_EN && tm) m.rgb = BARS[h / 80];
      else m.rgb = pixel_colour(h, v);
      m.fs = ((e % 2) == 0) && ((q % (HT * VT)) == 0);
    end
    return m;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_hs"}, int'(vga_hs), 1);
    check({tag, "_vs"}, int'(vga_vs), 1);
    check({tag, "_blank_n"}, int'(vga_blank_n), 0);
    check({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_sync_n"}, int'(vga_sync_n), 0);
  endtask

  task automatic release_and_run(input int n_clk);
    @(negedge clk);
    rst_n = 1'b1;
    {r_in, g_in, b_in} = pixel_colour(int'(x), int'(y));
    for (int e = 1; e <= n_clk; e++) begin
      @(negedge clk);
      sb_q.push_back(model(e, test_mode));
      {r_in, g_in, b_in} = pixel_colour(int'(x), int'(y));
    end
  endtask

  // Scoreboard monitor: outputs hold between ticks, so every clock is a comparison.
  initial begin : monitor
    exp_t exp_v, act_v;
    forever begin
      @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        act_v = {x, y, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start};
        n_checks++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t: got x=%0d y=%0d clk=%b hs=%b vs=%b bn=%b rgb=%06h fs=%b, required x=%0d y=%0d clk=%b hs=%b vs=%b bn=%b rgb=%06h fs=%b",
                   $time, act_v.x, act_v.y, act_v.vclk, act_v.hs, act_v.vs, act_v.blank_n,
                   act_v.rgb, act_v.fs, exp_v.x, exp_v.y, exp_v.vclk, exp_v.hs, exp_v.vs,
                   exp_v.blank_n, exp_v.rgb, exp_v.fs);
        end
      end
    end
  end

  initial begin : measure
    int hs_low, hs_since, vs_low, fs_since;
    logic hs_prev, vs_prev;
    forever begin
      @(negedge clk);
      #1;
      if (!meas_en) begin
        hs_low = 0; hs_since = -1; vs_low = 0; fs_since = -1;
        hs_prev = 1'b1; vs_prev = 1'b1;
      end else begin
        if (!vga_hs) hs_low++;
        else if (!hs_prev) begin check("hs_low_clks", hs_low, 2 * HSY); hs_low = 0; end
        if (hs_prev && !vga_hs) begin
          if (hs_since >= 0) check("line_period_clks", hs_since, 2 * HT);
          hs_since = 0;
        end
        if (hs_since >= 0) hs_since++;
        if (!vga_vs) vs_low++;
        else if (!vs_prev) begin check("vs_low_clks", vs_low, 2 * HT * VSY); vs_low = 0; end
        if (frame_start) begin
          if (fs_since >= 0) check("frame_period_clks", fs_since, 2 * HT * VT);
          fs_since = 0;
        end
        if (fs_since >= 0) fs_since++;
        hs_prev = vga_hs;
        vs_prev = vga_vs;
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 256; i++) begin
      lut_r[i] = 8'($urandom);
      lut_g[i] = 8'($urandom);
      lut_b[i] = 8'($urandom);
    end
    rst_n = 1'b0;
    test_mode = 1'b0;
    {r_in, g_in, b_in} = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    check_reset("reset_init");

    // Stop with x=300 on line 1, then reset asynchronously between edges.
    release_and_run(2 * (HT + 300));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_midline");
    repeat (3) @(negedge clk);
    check_reset("reset_held");

    test_mode = 1'b1;
    meas_en   = 1'b1;
    release_and_run(2 * HT * VT * 5 / 2);
    repeat (2) @(negedge clk);
    meas_en = 1'b0;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
